// File: rtl/instr_prefetch_unit_if.sv
// ============================================================================
// Module  : instr_prefetch_unit_if
// Brief   : Instruction-memory, decode-handshake and redirect signals of the
//           prefetch unit, with the unit side as master.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output if_valid, if_pc, if_inst,
    input  if_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  if_valid, if_pc, if_inst,
    output if_ready,
    output redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/instr_prefetch_unit.sv
// ============================================================================
// Module  : instr_prefetch_unit
// Brief   : Fetch front end with one outstanding request and a DEPTH-entry
//           {pc, inst} queue; optional counters under PREFETCH_STATS_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module instr_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  instr_prefetch_unit_if.master  bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [31:0]            stat_flushed
`endif
);

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_issue;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_valid;
  logic [31:0]     w_redirect_aligned;

  logic [31:0]     r_fetch_pc;
  logic            r_req;
  logic [31:0]     r_addr;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [AW:0]     r_count;
  logic [31:0]     r_pc_q   [DEPTH];
  logic [31:0]     r_inst_q [DEPTH];

  assign w_redirect_aligned = bus.redirect_pc & ~32'h3;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.if_ready && !bus.redirect_valid;

  // A request only goes out with a free slot, so the later push cannot overflow.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.redirect_valid && (r_count < c_DEPTH)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          w_push      = !bus.redirect_valid;
          w_drop      = bus.redirect_valid;
          w_state_nxt = S_IDLE;
        end else if (bus.redirect_valid) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.imem_rvalid) begin
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
    end else begin
      r_req <= w_issue;
      if (bus.redirect_valid) begin
        r_fetch_pc <= w_redirect_aligned;
        r_rd       <= '0;
        r_wr       <= '0;
        r_count    <= '0;
      end else begin
        if (w_issue) begin
          r_addr     <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr]   <= r_addr;
      r_inst_q[r_wr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.if_valid  = w_valid;
  assign bus.if_pc     = w_valid ? r_pc_q[r_rd]   : 32'd0;
  assign bus.if_inst   = w_valid ? r_inst_q[r_rd] : 32'd0;

`ifdef PREFETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_flushed;

  // Flushed = queued entries lost to a redirect plus each dropped response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      r_stat_fetched <= r_stat_fetched + 32'(w_push);
      r_stat_flushed <= r_stat_flushed
                        + (bus.redirect_valid ? 32'(r_count) : 32'd0)
                        + 32'(w_drop);
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
// ============================================================================
// Module  : tb_instr_prefetch_unit
// Brief   : Directed bench for instr_prefetch_unit with a variable-latency
//           memory model; stat checks only when PREFETCH_STATS_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat_cfg = 1;

  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'd0;

  instr_prefetch_unit_if bus();

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  instr_prefetch_unit #(.RESET_PC(32'h0), .DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_flushed (stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  // Memory answers lat_cfg cycles after the cycle the request is seen.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus.imem_rvalid = 1'b0;
      if (reset) begin
        m_pend = 1'b0;
      end else begin
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(m_addr);
            m_pend = 1'b0;
          end
        end
        if (bus.imem_req) begin
          m_pend = 1'b1;
          m_cnt  = lat_cfg;
          m_addr = bus.imem_addr;
        end
      end
    end
  end

  task automatic do_reset(input int lat);
    reset = 1'b1;
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    lat_cfg = lat;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.if_pc); end
    checks++; if (bus.if_inst !== 32'd0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus.if_inst); end
`ifdef PREFETCH_STATS_EN
    checks++; if (stat_fetched !== 32'd0) begin errors++; $display("FAIL reset_fetched got %h exp 0", stat_fetched); end
    checks++; if (stat_flushed !== 32'd0) begin errors++; $display("FAIL reset_flushed got %h exp 0", stat_flushed); end
`endif
  endtask

  task automatic test_in_order;
    int n;
    logic [31:0] e;
    do_reset(1);
    bus.if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 32'(i) * 32'd4;
      n = 0;
      while (!bus.if_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (bus.if_pc !== e) begin errors++; $display("FAIL order_pc%0d got %h exp %h", i, bus.if_pc, e); end
      checks++;
      if (bus.if_inst !== mem_word(e)) begin errors++; $display("FAIL order_inst%0d got %h exp %h", i, bus.if_inst, mem_word(e)); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int reqs;
    logic [31:0] e;
    do_reset(1);
    reqs = 0;
    repeat (30) begin @(negedge clk); if (bus.imem_req) reqs++; end
    checks++; if (reqs != 4) begin errors++; $display("FAIL full_reqs got %0d exp 4", reqs); end
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %h exp 1", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL full_head got %h exp 0", bus.if_pc); end
    bus.if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = 32'(i) * 32'd4;
      n = 0;
      while (!bus.if_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (bus.if_pc !== e) begin errors++; $display("FAIL drain_pc%0d got %h exp %h", i, bus.if_pc, e); end
      checks++;
      if (bus.if_inst !== mem_word(e)) begin errors++; $display("FAIL drain_inst%0d got %h exp %h", i, bus.if_inst, mem_word(e)); end
      @(negedge clk);
    end
    bus.if_ready = 1'b0;
  endtask

  task automatic test_redirect_wait;
    int n;
    do_reset(3);
    bus.if_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bus.imem_req && bus.imem_addr == 32'h10) && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rw_req10 timeout got %0d exp <100", n); end
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Stale response arrives now; an IDLE unit would already be requesting.
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rw_discard_req got %h exp 0", bus.imem_req); end
    n = 0;
    while (!bus.imem_req && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rw_addr got %h exp 40", bus.imem_addr); end
    n = 0;
    while (!bus.if_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.if_pc !== 32'h40) begin errors++; $display("FAIL rw_pc got %h exp 40", bus.if_pc); end
    checks++; if (bus.if_inst !== 32'hA500_0040) begin errors++; $display("FAIL rw_inst got %h exp a5000040", bus.if_inst); end
    bus.if_ready = 1'b0;
  endtask

  task automatic test_collision;
    int n;
    do_reset(2);
    n = 0;
    @(negedge clk);
    while (!(bus.imem_req && bus.imem_addr == 32'h8) && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL col_req8 timeout got %0d exp <100", n); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    bus.if_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.if_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL col_flush got %h exp 0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'd0) begin errors++; $display("FAIL col_pc_empty got %h exp 0", bus.if_pc); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL col_req got %h exp 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL col_addr got %h exp 80", bus.imem_addr); end
    n = 0;
    while (!bus.if_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.if_pc !== 32'h80) begin errors++; $display("FAIL col_head got %h exp 80", bus.if_pc); end
  endtask

  task automatic test_align;
    int n;
    do_reset(1);
    repeat (20) @(negedge clk);
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL al_head got %h exp 0", bus.if_pc); end
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h43;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL al_flush got %h exp 0", bus.if_valid); end
    n = 0;
    while (!bus.imem_req && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL al_addr got %h exp 40", bus.imem_addr); end
    n = 0;
    while (!bus.if_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus.if_inst !== 32'hA500_0040) begin errors++; $display("FAIL al_inst got %h exp a5000040", bus.if_inst); end
  endtask

  task automatic test_async_reset;
    do_reset(1);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %h exp 0", bus.if_valid); end
    checks++; if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL ar_addr got %h exp 0", bus.imem_addr); end
    checks++; if (bus.if_pc !== 32'd0) begin errors++; $display("FAIL ar_pc got %h exp 0", bus.if_pc); end
  endtask

`ifdef PREFETCH_STATS_EN
  task automatic test_stats;
    int n;
    do_reset(3);
    n = 0;
    @(negedge clk);
    while (!(bus.imem_req && bus.imem_addr == 32'h8) && n < 100) begin @(negedge clk); n++; end
    checks++; if (stat_fetched !== 32'd2) begin errors++; $display("FAIL st_fetched_pre got %0d exp 2", stat_fetched); end
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.if_valid && n < 30) begin @(negedge clk); n++; end
    checks++; if (bus.if_pc !== 32'h40) begin errors++; $display("FAIL st_pc got %h exp 40", bus.if_pc); end
    checks++; if (stat_fetched !== 32'd3) begin errors++; $display("FAIL st_fetched got %0d exp 3", stat_fetched); end
    checks++; if (stat_flushed !== 32'd3) begin errors++; $display("FAIL st_flushed got %0d exp 3", stat_flushed); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    test_reset();
    test_in_order();
    test_backpressure();
    test_redirect_wait();
    test_collision();
    test_align();
    test_async_reset();
`ifdef PREFETCH_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
